// File: rtl/pe_send_arbiter_pkg.sv
// Shared PE header: router/injection sizing, send-arbiter FSM encodings and
// requester indices used across the PE datapath.
package pe_send_arbiter_pkg;

  localparam int PE_ROUTER_ADDR_W = 6;
  localparam int PE_DATA_W        = 16;
  localparam int PE_SEND_CREDITS  = 4;
  localparam int PE_NUM_SEND_REQ  = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int REQ_PSUM   = 0;
  localparam int REQ_ACT    = 1;
  localparam int REQ_RESULT = 2;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pe_send_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first set req bit at or
// after ptr, wrapping modulo N. Shared by other PE resources.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_send_arbiter.sv
// PE send arbiter: round-robin burst-locked selection of send requesters into
// a credit-limited router injection port, with one registered output stage.
//
//  state  | meaning
//  IDLE   | no burst open; round-robin among all valid requesters from rr_ptr
//  LOCKED | burst open; only owner may transfer until its last flit
module pe_send_arbiter
  import pe_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = PE_NUM_SEND_REQ,
  parameter int DATA_WIDTH = PE_DATA_W,
  parameter int ADDR_WIDTH = PE_ROUTER_ADDR_W,
  parameter int CREDITS    = PE_SEND_CREDITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          credit_return,
  output logic                          send_en,
  output logic [DATA_WIDTH-1:0]         send_data,
  output logic [ADDR_WIDTH-1:0]         send_addr,
  output logic [1:0]                    send_src,
  output logic                          credit_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  logic [0:0]            state_q, state_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         credit_cnt_q, credit_cnt_d;
  logic                  credit_err_q, credit_err_d;
  logic                  send_en_q, send_en_d;
  logic [DATA_WIDTH-1:0] send_data_q, send_data_d;
  logic [ADDR_WIDTH-1:0] send_addr_q, send_addr_d;
  logic [1:0]            send_src_q, send_src_d;

  logic [NUM_REQ-1:0]    owner_mask;
  logic [NUM_REQ-1:0]    arb_req;
  logic [PW-1:0]         arb_ptr;
  logic [NUM_REQ-1:0]    arb_grant;
  logic                  xfer;
  logic [PW-1:0]         sel_idx;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // While locked, the owner is the only candidate; pointing the arbiter at it
  // keeps a single arbitration path for both states.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    if (state_q == ST_LOCKED) begin
      arb_req = req_valid & owner_mask;
      arb_ptr = owner_q;
    end else begin
      arb_req = req_valid;
      arb_ptr = rr_ptr_q;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .grant (arb_grant)
  );

  // Credits are taken from the registered count only; a returned credit is
  // never usable in the cycle it arrives.
  assign req_ready = (credit_cnt_q != '0) ? arb_grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    sel_idx  = '0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_idx  = PW'(i);
        sel_last = req_last[i];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = PW'(rr_next(32'(sel_idx), NUM_REQ));
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel_idx;
      end
    end
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (xfer && !credit_return) begin
      credit_cnt_d = credit_cnt_q - CW'(1);
    end else if (!xfer && credit_return) begin
      if (credit_cnt_q == CW'(CREDITS)) begin
        credit_err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    send_en_d   = xfer;
    send_data_d = xfer ? sel_data : '0;
    send_addr_d = xfer ? sel_addr : '0;
    send_src_d  = xfer ? 2'(sel_idx) : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_cnt_q <= CW'(CREDITS);
      credit_err_q <= 1'b0;
      send_en_q    <= 1'b0;
      send_data_q  <= '0;
      send_addr_q  <= '0;
      send_src_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      send_en_q    <= send_en_d;
      send_data_q  <= send_data_d;
      send_addr_q  <= send_addr_d;
      send_src_q   <= send_src_d;
    end
  end

  assign send_en    = send_en_q;
  assign send_data  = send_data_q;
  assign send_addr  = send_addr_q;
  assign send_src   = send_src_q;
  assign credit_err = credit_err_q;

endmodule
